// File: rtl/axil_regfile_if.sv
// AXI-lite bus bundle for axil_regfile: AW, W, B, AR and R channels.
// The master modport drives ms_* and the slave modport drives sm_*.
interface axil_regfile_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              ms_awvalid;
    logic [ADDR_W-1:0] ms_awaddr;
    logic              sm_awready;
    logic              ms_wvalid;
    logic [DATA_W-1:0] ms_wdata;
    logic              sm_wready;
    logic              sm_bvalid;
    logic [1:0]        sm_bresp;
    logic              ms_bready;
    logic              ms_arvalid;
    logic [ADDR_W-1:0] ms_araddr;
    logic              sm_arready;
    logic              sm_rvalid;
    logic [DATA_W-1:0] sm_rdata;
    logic [1:0]        sm_rresp;
    logic              ms_rready;

    modport master (
        output ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata, ms_bready,
        output ms_arvalid, ms_araddr, ms_rready,
        input  sm_awready, sm_wready, sm_bvalid, sm_bresp,
        input  sm_arready, sm_rvalid, sm_rdata, sm_rresp
    );

    modport slave (
        input  ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata, ms_bready,
        input  ms_arvalid, ms_araddr, ms_rready,
        output sm_awready, sm_wready, sm_bvalid, sm_bresp,
        output sm_arready, sm_rvalid, sm_rdata, sm_rresp
    );
endinterface

// File: rtl/axil_regfile.sv
// axil_regfile: AXI-lite slave register file, DEPTH x DATA_W.
// AW and W are captured independently into holding registers; the write
// commits on the first edge where both are available, then a B response
// is held until accepted. Reads load R data on the AR handshake.
// Optional feature macro AXIL_SLVERR_EN: out-of-range accesses return
// SLVERR (writes dropped, reads return 0). Without it the register index
// is the address modulo DEPTH (DEPTH must be a power of two) and every
// response is OKAY.
module axil_regfile #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input logic           clk,
    input logic           reset,
    axil_regfile_if.slave bus
);
    localparam int                IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    wstate_t           r_wstate;
    wstate_t           w_wstate_nxt;
    rstate_t           r_rstate;
    rstate_t           w_rstate_nxt;

    logic              r_aw_full;
    logic [ADDR_W-1:0] r_aw_addr;
    logic              r_w_full;
    logic [DATA_W-1:0] r_w_data;
    logic [1:0]        r_bresp;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;

`ifdef AXIL_SLVERR_EN
    // In range only when addr < DEPTH; the index is then just the low bits.
    function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W-1:0];
    endfunction
    assign w_wr_ok = ({1'b0, w_wr_addr} < LP_DEPTH);
    assign w_rd_ok = ({1'b0, bus.ms_araddr} < LP_DEPTH);
`else
    // Address aliases onto the array; with DEPTH a power of two this is a bit select.
    function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] addr);
        return IDX_W'({1'b0, addr} % LP_DEPTH);
    endfunction
    assign w_wr_ok = 1'b1;
    assign w_rd_ok = 1'b1;
`endif

    // Readies depend only on registered state, so no input-to-output path exists.
    assign bus.sm_awready = (r_wstate == W_IDLE) && !r_aw_full;
    assign bus.sm_wready  = (r_wstate == W_IDLE) && !r_w_full;
    assign bus.sm_arready = (r_rstate == R_IDLE);
    assign bus.sm_bvalid  = (r_wstate == W_RESP);
    assign bus.sm_bresp   = r_bresp;
    assign bus.sm_rvalid  = (r_rstate == R_DATA);
    assign bus.sm_rdata   = r_rdata;
    assign bus.sm_rresp   = r_rresp;

    assign w_aw_hs   = bus.ms_awvalid && bus.sm_awready;
    assign w_w_hs    = bus.ms_wvalid  && bus.sm_wready;
    assign w_ar_hs   = bus.ms_arvalid && bus.sm_arready;
    assign w_wr_addr = r_aw_full ? r_aw_addr : bus.ms_awaddr;
    assign w_wr_data = r_w_full  ? r_w_data  : bus.ms_wdata;
    assign w_commit  = (r_wstate == W_IDLE) && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
    assign w_wr_idx  = f_index(w_wr_addr);
    assign w_rd_idx  = f_index(bus.ms_araddr);

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Next-state logic: commit enters W_RESP, B/R handshakes return to idle.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_rstate_nxt = r_rstate;
        case (r_wstate)
            W_IDLE:  if (w_commit)      w_wstate_nxt = W_RESP;
            W_RESP:  if (bus.ms_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)       w_rstate_nxt = R_DATA;
            R_DATA:  if (bus.ms_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // AW/W holding registers, write commit into storage and B response code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_bresp   <= RESP_OKAY;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (w_wr_ok) r_mem[w_wr_idx] <= w_wr_data;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= bus.ms_awaddr;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= bus.ms_wdata;
            end
        end
    end

    // R data capture; a same-edge write commit is not yet visible here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
            r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end
endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile (ADDR_W=4, DATA_W=8).
// DEPTH is 12 when AXIL_SLVERR_EN is defined, 8 otherwise.
module tb_axil_regfile;
`ifdef AXIL_SLVERR_EN
    localparam int DEPTH = 12;
`else
    localparam int DEPTH = 8;
`endif

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    axil_regfile_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    axil_regfile #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".awready"}, bus.sm_awready, 1);
        check_val({tag, ".wready"},  bus.sm_wready,  1);
        check_val({tag, ".arready"}, bus.sm_arready, 1);
        check_val({tag, ".bvalid"},  bus.sm_bvalid,  0);
        check_val({tag, ".bresp"},   bus.sm_bresp,   0);
        check_val({tag, ".rvalid"},  bus.sm_rvalid,  0);
        check_val({tag, ".rdata"},   bus.sm_rdata,   0);
        check_val({tag, ".rresp"},   bus.sm_rresp,   0);
    endtask

    // Simultaneous AW+W with bready high: B lasts exactly one cycle.
    task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] d,
                            input logic [1:0] exp_resp);
        bus.ms_awvalid = 1; bus.ms_awaddr = a;
        bus.ms_wvalid  = 1; bus.ms_wdata  = d;
        bus.ms_bready  = 1;
        @(negedge clk);
        bus.ms_awvalid = 0; bus.ms_wvalid = 0;
        check_val({tag, ".bvalid"}, bus.sm_bvalid, 1);
        check_val({tag, ".bresp"},  bus.sm_bresp,  exp_resp);
        @(negedge clk);
        bus.ms_bready = 0;
        check_val({tag, ".bdone"},  bus.sm_bvalid, 0);
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [7:0] exp_d,
                           input logic [1:0] exp_resp);
        bus.ms_arvalid = 1; bus.ms_araddr = a; bus.ms_rready = 0;
        @(negedge clk);
        bus.ms_arvalid = 0;
        check_val({tag, ".rvalid"}, bus.sm_rvalid, 1);
        check_val({tag, ".rdata"},  bus.sm_rdata,  exp_d);
        check_val({tag, ".rresp"},  bus.sm_rresp,  exp_resp);
        bus.ms_rready = 1;
        @(negedge clk);
        bus.ms_rready = 0;
        check_val({tag, ".rdone"},  bus.sm_rvalid, 0);
    endtask

    initial begin
        reset = 1;
        bus.ms_awvalid = 0; bus.ms_awaddr = 0;
        bus.ms_wvalid  = 0; bus.ms_wdata  = 0;
        bus.ms_bready  = 0;
        bus.ms_arvalid = 0; bus.ms_araddr = 0;
        bus.ms_rready  = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 0;
        @(negedge clk);

        // Basic write then read back.
        do_write("wr3", 4'd3, 8'hA5, 2'b00);
        do_read ("rd3", 4'd3, 8'hA5, 2'b00);

        // W leads AW by two cycles, bready held low for three cycles.
        bus.ms_wvalid = 1; bus.ms_wdata = 8'h3C; bus.ms_bready = 0;
        @(negedge clk);
        bus.ms_wvalid = 0;
        check_val("wlead.wready",  bus.sm_wready,  0);
        check_val("wlead.awready", bus.sm_awready, 1);
        check_val("wlead.bvalid",  bus.sm_bvalid,  0);
        @(negedge clk);
        check_val("wlead.wready2", bus.sm_wready,  0);
        bus.ms_awvalid = 1; bus.ms_awaddr = 4'd7;
        @(negedge clk);
        bus.ms_awvalid = 0;
        check_val("wlead.bvalid1", bus.sm_bvalid, 1);
        check_val("wlead.bresp1",  bus.sm_bresp,  0);
        check_val("wlead.awready1", bus.sm_awready, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("wlead.bhold",   bus.sm_bvalid,  1);
            check_val("wlead.bresph",  bus.sm_bresp,   0);
            check_val("wlead.wreadyh", bus.sm_wready,  0);
            check_val("wlead.awreadyh", bus.sm_awready, 0);
        end
        bus.ms_bready = 1;
        @(negedge clk);
        bus.ms_bready = 0;
        check_val("wlead.bdone",    bus.sm_bvalid,  0);
        check_val("wlead.awready2", bus.sm_awready, 1);
        check_val("wlead.wready3",  bus.sm_wready,  1);

        // Read on the same edge as a commit to the same address sees old data.
        bus.ms_awvalid = 1; bus.ms_awaddr = 4'd7;
        bus.ms_wvalid  = 1; bus.ms_wdata  = 8'h11;
        bus.ms_arvalid = 1; bus.ms_araddr = 4'd7;
        bus.ms_bready  = 1; bus.ms_rready = 0;
        @(negedge clk);
        bus.ms_awvalid = 0; bus.ms_wvalid = 0; bus.ms_arvalid = 0;
        check_val("coll.bvalid", bus.sm_bvalid, 1);
        check_val("coll.rvalid", bus.sm_rvalid, 1);
        check_val("coll.rdata",  bus.sm_rdata,  8'h3C);
        bus.ms_rready = 1;
        @(negedge clk);
        bus.ms_rready = 0; bus.ms_bready = 0;
        do_read("coll.after", 4'd7, 8'h11, 2'b00);

`ifdef AXIL_SLVERR_EN
        do_write("oor.wr13", 4'd13, 8'hFF, 2'b10);
        do_read ("oor.rd13", 4'd13, 8'h00, 2'b10);
        do_read ("oor.rd3",  4'd3,  8'hA5, 2'b00);
        do_read ("oor.rd7",  4'd7,  8'h11, 2'b00);
        do_read ("oor.rd1",  4'd1,  8'h00, 2'b00);
        do_read ("oor.rd11", 4'd11, 8'h00, 2'b00);
`else
        do_write("alias.wr12", 4'd12, 8'h5A, 2'b00);
        do_read ("alias.rd4",  4'd4,  8'h5A, 2'b00);
        do_read ("alias.rd12", 4'd12, 8'h5A, 2'b00);
        do_read ("alias.rd3",  4'd3,  8'hA5, 2'b00);
        do_read ("alias.rd15", 4'd15, 8'h11, 2'b00);
`endif

        // Reset while R is pending and AW is held.
        bus.ms_arvalid = 1; bus.ms_araddr = 4'd3; bus.ms_rready = 0;
        bus.ms_awvalid = 1; bus.ms_awaddr = 4'd5;
        @(negedge clk);
        bus.ms_arvalid = 0; bus.ms_awvalid = 0;
        check_val("mid.rvalid",  bus.sm_rvalid,  1);
        check_val("mid.rdata",   bus.sm_rdata,   8'hA5);
        check_val("mid.awready", bus.sm_awready, 0);
        reset = 1;
        #1;
        check_reset_outputs("mid.rst");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        // A stale held AW would let this lone W commit.
        bus.ms_wvalid = 1; bus.ms_wdata = 8'h77; bus.ms_bready = 1;
        @(negedge clk);
        bus.ms_wvalid = 0;
        check_val("post.bvalid0", bus.sm_bvalid, 0);
        check_val("post.wready",  bus.sm_wready, 0);
        bus.ms_awvalid = 1; bus.ms_awaddr = 4'd6;
        @(negedge clk);
        bus.ms_awvalid = 0;
        check_val("post.bvalid1", bus.sm_bvalid, 1);
        @(negedge clk);
        bus.ms_bready = 0;
        do_read("post.rd3", 4'd3, 8'h00, 2'b00);
        do_read("post.rd7", 4'd7, 8'h00, 2'b00);
        do_read("post.rd6", 4'd6, 8'h77, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_regfile.md
# axil_regfile

Parametrised AXI-lite slave register file, the next generation of the switch-driven AXI slave behind the Tiny Tapeout wrapper. It adds configurable address/data width and depth, independent AW/W acceptance, a write-response (B) channel, and response codes on both write and read. It sits directly below the top-level pin wrapper, which drives the master-side signals from pins; alternatively it sits behind a small internal master.

## Interface
Parameters:
- ADDR_W, 4, address width in bits
- DATA_W, 8, register data width in bits
- DEPTH, 16, number of registers; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- ms_awvalid  in  1  write address valid
- ms_awaddr  in  ADDR_W  write address
- sm_awready  out  1  write address ready
- ms_wvalid  in  1  write data valid
- ms_wdata  in  DATA_W  write data
- sm_wready  out  1  write data ready
- sm_bvalid  out  1  write response valid
- sm_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- ms_bready  in  1  write response ready
- ms_arvalid  in  1  read address valid
- ms_araddr  in  ADDR_W  read address
- sm_arready  out  1  read address ready
- sm_rvalid  out  1  read data valid
- sm_rdata  out  DATA_W  read data
- sm_rresp  out  2  read response, same encoding as sm_bresp
- ms_rready  in  1  read data ready

## Operation
- Storage: DEPTH × DATA_W registers. All registers are cleared to 0 on reset.
- Write FSM states: W_IDLE and W_RESP.
  - Holding registers aw_hold and w_hold each carry a full flag.
  - sm_awready = W_IDLE && !aw_full.
  - sm_wready = W_IDLE && !w_full.
  - An AW handshake captures the address. A W handshake captures the data. The two handshakes may occur in either order or in the same cycle.
  - At the first edge where both are available (held, or handshaking that cycle), the write commits to storage, both full flags clear, the FSM moves to W_RESP, and sm_bvalid is set with sm_bresp set.
  - W_RESP: sm_bvalid and sm_bresp are held stable until ms_bready is sampled high, then the FSM returns to W_IDLE.
- Read FSM states: R_IDLE and R_DATA.
  - sm_arready = R_IDLE.
  - An AR handshake loads sm_rdata and sm_rresp, sets sm_rvalid, and moves the FSM to R_DATA.
  - sm_rdata and sm_rresp are held stable until ms_rready is sampled high, then the FSM returns to R_IDLE.
- The read and write channels are fully independent and may be active in the same cycle.
- Same-edge conflict: a read captured on the same edge as a write commit to the same address returns the old (pre-write) value.
- Out-of-range address (addr ≥ DEPTH): behaviour is set by the macro; see Configuration.

## Timing
- Reset values: sm_awready=1, sm_wready=1, sm_arready=1, sm_bvalid=0, sm_bresp=2'b00, sm_rvalid=0, sm_rdata=0, sm_rresp=2'b00.
- Reset asserted mid-transaction: held AW/W and any pending B/R responses are discarded, and the register contents are cleared.
- Write latency: AW and W handshakes on edge N → register updated and sm_bvalid=1 after edge N. If AW and W arrive on different edges, the commit happens on the later edge.
- Write throughput: the next AW/W handshake is possible in the cycle after the B handshake. Best case is one write per 2 cycles.
- Read latency: AR handshake on edge N → sm_rvalid=1 with data after edge N.
- Read throughput: the next AR handshake is possible in the cycle after the R handshake. Best case is one read per 2 cycles.
- sm_awready, sm_wready and sm_arready are combinational functions of registered state only. There is no combinational path from any input to any output.
- A valid that is held while the corresponding ready is low is not captured. Masters must keep the payload stable until the handshake completes.

## Configuration
- AXIL_SLVERR_EN defined:
  - Out-of-range write: storage is unchanged and sm_bresp=2'b10.
  - Out-of-range read: sm_rdata=0 and sm_rresp=2'b10.
  - In-range accesses return 2'b00.
- AXIL_SLVERR_EN undefined:
  - Register index = address mod DEPTH.
  - All responses are 2'b00.
  - DEPTH must be a power of two, so the index is the low address bits.

## Test plan
- Reset, then simultaneous AW(addr 3)+W(0xA5) with ms_bready=1 → sm_bvalid=1 for one cycle with bresp 00. Then AR(addr 3) → sm_rdata=0xA5, rresp 00.
- W(0x3C) two cycles before AW(addr 7), ms_bready held low 3 cycles → sm_wready=0 after the W handshake. sm_bvalid stays 1 with stable bresp until bready. AW/W readies return only after the B handshake.
- AR(addr 7) on the same edge as a write commit of 0x11 to addr 7 → sm_rdata returns the old value 0x3C. A following read returns 0x11.
- DEPTH=12, AXIL_SLVERR_EN defined: write 0xFF to addr 13 → bresp 10. Read addr 13 → rdata 0, rresp 10. All in-range registers are unchanged.
- DEPTH=8, AXIL_SLVERR_EN undefined: write 0x5A to addr 12 → bresp 00. Read addr 4 → 0x5A.
- Assert reset while sm_rvalid=1 and AW is held → all outputs return to their reset values. A read of any address afterwards returns 0.
